// File: rtl/timepulse_gen.sv
// Divides clk into twelve one-hot timepulses T01..T12 forming one memory cycle time, with free-run and single-MCT step modes.
// Optional two-phase clock outputs ph1/ph2 are compiled in when TP_PHASE_OUT_EN is defined.
module timepulse_gen #(
    parameter int DIV    = 8,
    parameter int TP_RST = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        step_req,
    output logic        step_ack,
    output logic [11:0] tp,
    output logic [3:0]  tp_num,
    output logic        mct,
    output logic        busy,
`ifdef TP_PHASE_OUT_EN
    output logic        ph1,
    output logic        ph2,
`endif
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2
    } state_t;

    localparam int             CW         = $clog2(DIV);
    localparam logic [CW-1:0]  DIV_LAST   = CW'(DIV - 1);
    localparam logic [11:0]    TP_RST_OH  = 12'd1 << (TP_RST - 1);
    localparam logic [3:0]     TP_RST_NUM = 4'(TP_RST);

    state_t        r_state;
    logic [CW-1:0] r_div;
    logic [11:0]   r_tp;
    logic [3:0]    r_tp_num;
    logic          r_step_ack;
    logic          r_mct;

    state_t        w_state_nxt;
    logic [CW-1:0] w_div_nxt;
    logic [11:0]   w_tp_nxt;
    logic [3:0]    w_tp_num_nxt;
    logic          w_ack_nxt;
    logic          w_mct_nxt;
    logic          w_busy_nxt;
    logic          w_tp_end;

    assign w_tp_end = (r_div == DIV_LAST);

    // Next-state values; every output is registered from these so the outputs
    // always describe the state the FSM is in, not the one it is leaving.
    always_comb begin
        w_state_nxt  = r_state;
        w_div_nxt    = r_div;
        w_tp_nxt     = r_tp;
        w_tp_num_nxt = r_tp_num;
        w_ack_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run) begin
                    w_state_nxt  = S_RUN;
                    w_tp_nxt     = 12'h001;
                    w_tp_num_nxt = 4'd1;
                    w_div_nxt    = '0;
                end else if (step_req && !r_step_ack) begin
                    w_state_nxt  = S_STEP;
                    w_tp_nxt     = 12'h001;
                    w_tp_num_nxt = 4'd1;
                    w_div_nxt    = '0;
                end
            end
            default: begin
                w_div_nxt = w_tp_end ? '0 : r_div + CW'(1);
                if (w_tp_end) begin
                    if (r_tp[11]) begin
                        if (r_state == S_RUN && run) begin
                            w_tp_nxt     = 12'h001;
                            w_tp_num_nxt = 4'd1;
                        end else begin
                            // Stop on the MCT boundary, holding T12.
                            w_state_nxt = S_IDLE;
                            w_ack_nxt   = (r_state == S_STEP);
                        end
                    end else begin
                        w_tp_nxt     = {r_tp[10:0], r_tp[11]};
                        w_tp_num_nxt = r_tp_num + 4'd1;
                    end
                end
            end
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_mct_nxt  = w_busy_nxt && w_tp_nxt[11] && (w_div_nxt == DIV_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_div      <= '0;
            r_tp       <= TP_RST_OH;
            r_tp_num   <= TP_RST_NUM;
            r_step_ack <= 1'b0;
            r_mct      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_div      <= w_div_nxt;
            r_tp       <= w_tp_nxt;
            r_tp_num   <= w_tp_num_nxt;
            r_step_ack <= w_ack_nxt;
            r_mct      <= w_mct_nxt;
        end
    end

`ifdef TP_PHASE_OUT_EN
    localparam logic [CW-1:0] HALF_M2 = CW'(DIV / 2 - 2);
    localparam logic [CW-1:0] HALF    = CW'(DIV / 2);

    logic r_ph1;
    logic r_ph2;

    // Non-overlapping phases with dead bands at DIV/2-1 and DIV-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ph1 <= 1'b0;
            r_ph2 <= 1'b0;
        end else begin
            r_ph1 <= w_busy_nxt && (w_div_nxt <= HALF_M2);
            r_ph2 <= w_busy_nxt && (w_div_nxt >= HALF) && (w_div_nxt != DIV_LAST);
        end
    end

    assign ph1 = r_ph1;
    assign ph2 = r_ph2;
`endif

    assign tp        = r_tp;
    assign tp_num    = r_tp_num;
    assign step_ack  = r_step_ack;
    assign mct       = r_mct;
    assign busy      = (r_state != S_IDLE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_timepulse_gen.sv
// Bench for timepulse_gen: directed scenarios plus random run/step/reset traffic,
// checked every cycle against a position-in-MCT model.
module tb_timepulse_gen;

    localparam int DIV    = 4;
    localparam int TP_RST = 12;
    localparam int MCT_LEN = 12 * DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        step_req;
    logic        step_ack;
    logic [11:0] tp;
    logic [3:0]  tp_num;
    logic        mct;
    logic        busy;
    logic [1:0]  dbg_state;
`ifdef TP_PHASE_OUT_EN
    logic        ph1;
    logic        ph2;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    timepulse_gen #(.DIV(DIV), .TP_RST(TP_RST)) dut (
        .clk(clk),
        .rst(rst),
        .run(run),
        .step_req(step_req),
        .step_ack(step_ack),
        .tp(tp),
        .tp_num(tp_num),
        .mct(mct),
        .busy(busy),
`ifdef TP_PHASE_OUT_EN
        .ph1(ph1),
        .ph2(ph2),
`endif
        .dbg_state(dbg_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an active flag plus the cycle position within the current MCT.
    bit m_valid  = 1'b0;
    bit m_active = 1'b0;
    bit m_step   = 1'b0;
    bit m_ack    = 1'b0;
    int m_pos    = 0;
    int m_idle_num = TP_RST;

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b1; m_active = 1'b0; m_step = 1'b0;
            m_ack = 1'b0; m_pos = 0; m_idle_num = TP_RST;
        end else if (!m_active) begin
            if (run) begin
                m_active = 1'b1; m_step = 1'b0; m_pos = 0;
            end else if (step_req && !m_ack) begin
                m_active = 1'b1; m_step = 1'b1; m_pos = 0;
            end
            m_ack = 1'b0;
        end else if (m_pos == MCT_LEN - 1) begin
            if (!m_step && run) begin
                m_pos = 0; m_ack = 1'b0;
            end else begin
                m_active = 1'b0; m_idle_num = 12; m_ack = m_step;
            end
        end else begin
            m_pos++; m_ack = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            int e_num;
            int phase;
            logic [11:0] e_tp;
            e_num = m_active ? (m_pos / DIV + 1) : m_idle_num;
            e_tp  = 12'd1 << (e_num - 1);
            phase = m_pos % DIV;
            check("tp", 32'(tp), 32'(e_tp));
            check("tp_num", 32'(tp_num), 32'(e_num));
            check("busy", 32'(busy), 32'(m_active));
            check("mct", 32'(mct), 32'(m_active && m_pos == MCT_LEN - 1));
            check("step_ack", 32'(step_ack), 32'(m_ack));
            check("dbg_state_busy", 32'(dbg_state != 2'd0), 32'(m_active));
`ifdef TP_PHASE_OUT_EN
            check("ph1", 32'(ph1), 32'(m_active && phase <= DIV / 2 - 2));
            check("ph2", 32'(ph2), 32'(m_active && phase >= DIV / 2 && phase <= DIV - 2));
            check("ph_overlap", 32'(ph1 & ph2), 32'd0);
`endif
        end
    end

    task automatic wait_tp_num(input logic [3:0] n, input string name);
        int k;
        k = 0;
        while (!(busy && tp_num == n) && k < 3 * MCT_LEN) begin
            @(negedge clk);
            k++;
        end
        check({name, "_reached"}, 32'(busy && tp_num == n), 32'd1);
    endtask

    initial begin
        int busy_cnt;
        int mct_cnt;
        int ack_cnt;
        int k;

        rst = 1'b1; run = 1'b0; step_req = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tp", 32'(tp), 32'h800);
        check("rst_tp_num", 32'(tp_num), 32'd12);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("idle_hold_tp", 32'(tp), 32'h800);

        // Free run, then drop run during T05.
        run = 1'b1;
        @(negedge clk);
        check("run_start_tp", 32'(tp), 32'h001);
        repeat (100) @(negedge clk);
        wait_tp_num(4'd5, "t05");
        run = 1'b0;
        k = 0;
        while (busy && k < MCT_LEN + 2) begin
            @(negedge clk);
            k++;
        end
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_tp", 32'(tp), 32'h800);
        mct_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (mct) mct_cnt++;
        end
        check("stop_no_mct", 32'(mct_cnt), 32'd0);

        // One step, requester holds step_req until step_ack.
        step_req = 1'b1;
        busy_cnt = 0; mct_cnt = 0; ack_cnt = 0; k = 0;
        while (ack_cnt == 0 && k < 2 * MCT_LEN + 4) begin
            @(negedge clk);
            k++;
            if (busy) busy_cnt++;
            if (mct) mct_cnt++;
            if (step_ack) ack_cnt++;
        end
        step_req = 1'b0;
        check("step_ack_seen", 32'(ack_cnt), 32'd1);
        check("step_busy_cycles", 32'(busy_cnt), 32'd48);
        check("step_mct_count", 32'(mct_cnt), 32'd1);
        busy_cnt = 0; ack_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (step_ack) ack_cnt++;
        end
        check("step_stays_idle", 32'(busy_cnt), 32'd0);
        check("step_ack_once", 32'(ack_cnt), 32'd0);

        // Reset during T07 of a step abandons it.
        step_req = 1'b1;
        wait_tp_num(4'd7, "t07");
        rst = 1'b1;
        @(negedge clk);
        check("midrst_tp", 32'(tp), 32'h800);
        check("midrst_busy", 32'(busy), 32'd0);
        rst = 1'b0; step_req = 1'b0;
        ack_cnt = 0;
        repeat (2 * MCT_LEN) begin
            @(negedge clk);
            if (step_ack) ack_cnt++;
        end
        check("midrst_no_ack", 32'(ack_cnt), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) run = ~run;
            if ($urandom_range(0, 19) == 0) step_req = ~step_req;
            rst = ($urandom_range(0, 399) == 0);
            @(negedge clk);
        end
        rst = 1'b0; run = 1'b0; step_req = 1'b0;
        repeat (2 * MCT_LEN) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
